multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control unit for the multicycle MIPS datapath. A Moore-style state machine sequences each instruction through fetch, decode, execute, memory and write-back. It decodes the opcode and funct fields of the instruction-register output and drives every enable and select of the memory, PC register, instruction register, register file and ALU. It sits directly upstream of the datapath and consumes only the instruction bits and the ALU `Zero` flag.

## Interface
Parameters:
- none

Ports:
- `Clk` in 1: rising-edge clock shared with the datapath.
- `Rst` in 1: reset, asynchronous, active-low.
- `Opcode` in 6: IR[31:26].
- `Funct` in 6: IR[5:0].
- `Zero` in 1: ALU zero flag.
- `MemRead`, `MemWrite` out 1: memory strobes.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction register load.
- `PCWrite_1` out 1: PC load enable.
- `PCWrite_2` out 1: PC takes register value (jr).
- `PCSource` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `RegWrite`, `RegDst`, `Jal`, `MemtoReg` out 1: register-file controls.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `Function` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `State` out 4: current state, for debug and bench.

## Operation
- Supported instructions:
  - R-type: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, j 000010, jal 000011, addi 001000.
- States and their outputs (every output not listed is 0):
  - FETCH(0): MemRead, IRWrite, ALUSrcB=01, Function=000, PCSource=00, PCWrite_1. Next: DECODE.
  - DECODE(1): ALUSrcB=11, Function=000, so ALUOut captures the branch target. Next state by opcode:
    - lw/sw → MEMADR
    - R-type with funct jr → JR
    - other R-type → RTEXE
    - beq → BRANCH, j → JUMP, jal → JAL, addi → ADDIEXE
    - otherwise → ILLEGAL handling
  - MEMADR(2): ALUSrcA, ALUSrcB=10, Function=000. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD(3): MemRead, IorD. Next: MEMWB.
  - MEMWB(4): RegWrite, MemtoReg, RegDst=0. Next: FETCH.
  - MEMWR(5): MemWrite, IorD. Next: FETCH.
  - RTEXE(6): ALUSrcA, ALUSrcB=00, Function from funct decode. Next: RTWB.
  - RTWB(7): RegWrite, RegDst=1, MemtoReg=0, Function held. Next: FETCH.
  - BRANCH(8): ALUSrcA, ALUSrcB=00, Function=001, PCSource=01, PCWrite_1=Zero. This is the only combinational (Mealy) term. Next: FETCH.
  - JUMP(9): PCSource=10, PCWrite_1. Next: FETCH.
  - JAL(10): PCSource=10, PCWrite_1, RegWrite, Jal. r31 receives the already-incremented PC, read before the same-edge update. Next: FETCH.
  - JR(11): PCWrite_1, PCWrite_2. Next: FETCH.
  - ADDIEXE(12): ALUSrcA, ALUSrcB=10, Function=000. Next: ADDIWB.
  - ADDIWB(13): RegWrite, RegDst=0, MemtoReg=0. Next: FETCH.
- Unknown funct under R-type decodes Function=000; the instruction completes as add.

## Timing
- CPI: lw 5; sw, R-type and addi 4; beq, j, jal and jr 3.
- The state register updates on the rising edge of `Clk`. Outputs decode from the registered state; only BRANCH's `PCWrite_1` also depends on `Zero`.
- While `Rst` is low, the state is forced to FETCH immediately and all outputs are forced to 0, overriding the FETCH decode. The first fetch edge is the first rising edge after `Rst` goes high.
- Reset asserted mid-instruction abandons the instruction. No partial write occurs after the asynchronous assertion.
- Back-to-back instructions: FETCH always follows the final state with no bubble.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to HALT(14).
  - HALT: all outputs 0, `State`=14, stays until reset.
- `ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode in DECODE returns to FETCH, treating the instruction as a 2-cycle no-op.
  - State 14 is unreachable.

## Structure
- Shared package `mips_ctrl_pkg`:
  - opcode constants and funct constants
  - 3-bit ALU function codes
  - 4-bit state encoding
- One sub-module, `alu_decoder`: combinational Funct → Function, used in RTEXE/RTWB.

## Test plan
- Reset: hold `Rst` low → all outputs 0 and `State`=0. Release → on the next edge `State`=1, and during state 0 MemRead=IRWrite=PCWrite_1=1.
- lw (Opcode 100011) → State sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
- R-type sub (Funct 100010) → states 0,1,6,7. Function=001 in states 6 and 7; RegDst=1 and RegWrite=1 in state 7.
- beq: in state 8 with Zero=1 → PCWrite_1=1, PCSource=01. Repeat with Zero=0 → PCWrite_1=0.
- jal → states 0,1,10 with Jal=1, RegWrite=1, PCSource=10. jr → state 11 with PCWrite_1=1 and PCWrite_2=1.
- Opcode 111111:
  - with `ILLEGAL_TRAP_EN` → `State`=14, held for 10 cycles, all outputs 0.
  - without it → `State` returns to 0 after state 1.
  - Asserting `Rst` during state 3 → `State`=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, ALU function codes and state encoding for the multicycle MIPS control unit
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_JAL     = 4'd10,
        S_JR      = 4'd11,
        S_ADDIEXE = 4'd12,
        S_ADDIWB  = 4'd13,
        S_HALT    = 4'd14
    } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: R-type funct field to 3-bit ALU operation; unknown funct falls back to add
// Ports: funct (IR[5:0]) in, alu_fn (ALU operation) out
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_fn
);
    always_comb alu_fn = funct == F_SUB ? ALU_SUB :
                         funct == F_AND ? ALU_AND :
                         funct == F_OR  ? ALU_OR  :
                         funct == F_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/write-back for the multicycle MIPS datapath
// Ports: Clk, Rst (async active-low), Opcode/Funct (IR fields), Zero (ALU flag) in;
//        memory, PC, IR, register-file and ALU controls plus State (debug) out.
// Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to a HALT state instead of a 2-cycle no-op.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite_1,
    output logic       PCWrite_2,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       Jal,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] Function,
    output logic [3:0] State
);
    state_t state, next;
    logic [2:0] rt_fn;
    alu_decoder u_alu_decoder (.funct(Funct), .alu_fn(rt_fn));
    always_ff @(posedge Clk or negedge Rst)
        if (!Rst) state <= S_FETCH;
        else      state <= next;
    assign State = state;
    always_comb begin
        next      = S_FETCH;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite_1 = 1'b0;
        PCWrite_2 = 1'b0;
        PCSource  = 2'b00;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        Jal       = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        Function  = ALU_ADD;
        case (state)
            S_FETCH: begin
                MemRead   = 1'b1;
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b01;
                PCWrite_1 = 1'b1;
                next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = Funct == F_JR ? S_JR : S_RTEXE;
                    OP_BEQ:       next = S_BRANCH;
                    OP_J:         next = S_JUMP;
                    OP_JAL:       next = S_JAL;
                    OP_ADDI:      next = S_ADDIEXE;
`ifdef ILLEGAL_TRAP_EN
                    default:      next = S_HALT;
`else
                    default:      next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = Opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTEXE: begin
                ALUSrcA  = 1'b1;
                Function = rt_fn;
                next     = S_RTWB;
            end
            S_RTWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                Function = rt_fn;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                Function  = ALU_SUB;
                PCSource  = 2'b01;
                PCWrite_1 = Zero;
            end
            S_JUMP: begin
                PCSource  = 2'b10;
                PCWrite_1 = 1'b1;
            end
            S_JAL: begin
                PCSource  = 2'b10;
                PCWrite_1 = 1'b1;
                RegWrite  = 1'b1;
                Jal       = 1'b1;
            end
            S_JR: begin
                PCWrite_1 = 1'b1;
                PCWrite_2 = 1'b1;
            end
            S_ADDIEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            S_HALT: next = S_HALT;
`endif
            default: next = S_FETCH;
        endcase
        // Reset overrides the FETCH decode so nothing strobes while held.
        if (!Rst) begin
            MemRead   = 1'b0;
            IRWrite   = 1'b0;
            ALUSrcB   = 2'b00;
            PCWrite_1 = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven and randomized checks of multicycle_controller against a spec-level model
module tb_multicycle_controller;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011, ADDI = 6'b001000, RT = 6'b000000, BAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010, FJR = 6'b001000;
    logic Clk = 1'b0, Rst = 1'b0, Zero = 1'b0;
    logic [5:0] Opcode = '0, Funct = '0;
    logic MemRead, MemWrite, IorD, IRWrite, PCWrite_1, PCWrite_2, RegWrite, RegDst, Jal, MemtoReg, ALUSrcA;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] Function;
    logic [3:0] State;
    logic [17:0] outs;
    int errors = 0, checks = 0;
    always #5 Clk = ~Clk;
    multicycle_controller dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite_1(PCWrite_1), .PCWrite_2(PCWrite_2), .PCSource(PCSource),
        .RegWrite(RegWrite), .RegDst(RegDst), .Jal(Jal), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Function(Function), .State(State)
    );
    assign outs = {MemRead, MemWrite, IorD, IRWrite, PCWrite_1, PCWrite_2, PCSource,
                   RegWrite, RegDst, Jal, MemtoReg, ALUSrcA, ALUSrcB, Function};
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask
    function automatic logic [2:0] rfn(input logic [5:0] fn);
        case (fn)
            FSUB: return 3'd1;
            FAND: return 3'd2;
            FOR:  return 3'd3;
            FSLT: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction
    function automatic logic [17:0] exp_out(input logic [3:0] s, input logic [5:0] fn, input logic z);
        logic mr = 0, mw = 0, iord = 0, irw = 0, pw1 = 0, pw2 = 0, rw = 0, rd = 0, jl = 0, m2r = 0, sa = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [2:0] f = 0;
        case (s)
            0: begin mr = 1; irw = 1; sb = 1; pw1 = 1; end
            1: sb = 3;
            2: begin sa = 1; sb = 2; end
            3: begin mr = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = 1; iord = 1; end
            6: begin sa = 1; f = rfn(fn); end
            7: begin rw = 1; rd = 1; f = rfn(fn); end
            8: begin sa = 1; f = 1; ps = 1; pw1 = z; end
            9: begin ps = 2; pw1 = 1; end
            10: begin ps = 2; pw1 = 1; rw = 1; jl = 1; end
            11: begin pw1 = 1; pw2 = 1; end
            12: begin sa = 1; sb = 2; end
            13: rw = 1;
            default: ;
        endcase
        return {mr, mw, iord, irw, pw1, pw2, ps, rw, rd, jl, m2r, sa, sb, f};
    endfunction
    // Instruction-class model: state path and CPI per instruction.
    function automatic void seq_of(input logic [5:0] op, input logic [5:0] fn, output int cpi, output logic [19:0] seq);
        case (op)
            LW:   begin cpi = 5; seq = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; end
            SW:   begin cpi = 4; seq = {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}; end
            RT:   if (fn == FJR) begin cpi = 3; seq = {4'd0, 4'd1, 4'd11, 8'd0}; end
                  else begin cpi = 4; seq = {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}; end
            BEQ:  begin cpi = 3; seq = {4'd0, 4'd1, 4'd8, 8'd0}; end
            J:    begin cpi = 3; seq = {4'd0, 4'd1, 4'd9, 8'd0}; end
            JAL:  begin cpi = 3; seq = {4'd0, 4'd1, 4'd10, 8'd0}; end
            ADDI: begin cpi = 4; seq = {4'd0, 4'd1, 4'd12, 4'd13, 4'd0}; end
            default: begin cpi = 2; seq = {4'd0, 4'd1, 12'd0}; end
        endcase
    endfunction
    // Entered just after a falling edge with State at FETCH; leaves just after a falling edge in the next FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cpi,
                       input logic [19:0] seq, input string tag);
        Opcode = op;
        Funct = fn;
        Zero = z;
        for (int i = 0; i < cpi; i++) begin
            logic [3:0] s;
            s = seq[19-4*i -: 4];
            if (i > 0) @(negedge Clk);
            #1;
            chk($sformatf("%s state%0d", tag, i), 32'(State), 32'(s));
            chk($sformatf("%s outs%0d", tag, i), 32'(outs), 32'(exp_out(s, fn, z)));
        end
        @(negedge Clk);
        #1;
        chk($sformatf("%s return", tag), 32'(State), 32'd0);
    endtask
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic z;
        int cpi;
        logic [19:0] seq;
        string name;
    } vec_t;
    vec_t vt[$];
    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [6];
        int cpi;
        logic [19:0] seq;
        vt.push_back('{LW,   6'd0, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, "lw"});
        vt.push_back('{SW,   6'd0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}, "sw"});
        vt.push_back('{RT,   FADD, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "add"});
        vt.push_back('{RT,   FSUB, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "sub"});
        vt.push_back('{RT,   FAND, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "and"});
        vt.push_back('{RT,   FOR,  1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "or"});
        vt.push_back('{RT,   FSLT, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "slt"});
        vt.push_back('{RT,   6'b111111, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}, "rt_unknown"});
        vt.push_back('{RT,   FJR,  1'b0, 3, {4'd0, 4'd1, 4'd11, 8'd0}, "jr"});
        vt.push_back('{BEQ,  6'd0, 1'b1, 3, {4'd0, 4'd1, 4'd8, 8'd0}, "beq_taken"});
        vt.push_back('{BEQ,  6'd0, 1'b0, 3, {4'd0, 4'd1, 4'd8, 8'd0}, "beq_not"});
        vt.push_back('{J,    6'd0, 1'b0, 3, {4'd0, 4'd1, 4'd9, 8'd0}, "j"});
        vt.push_back('{JAL,  6'd0, 1'b0, 3, {4'd0, 4'd1, 4'd10, 8'd0}, "jal"});
        vt.push_back('{ADDI, 6'd5, 1'b0, 4, {4'd0, 4'd1, 4'd12, 4'd13, 4'd0}, "addi"});
        ops = '{RT, RT, LW, SW, BEQ, J, JAL, ADDI};
        fns = '{FADD, FSUB, FAND, FOR, FSLT, FJR};
        Opcode = LW;
        repeat (2) @(negedge Clk);
        #1;
        chk("reset state", 32'(State), 32'd0);
        chk("reset outs", 32'(outs), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < vt.size(); k++)
            run(vt[k].op, vt[k].fn, vt[k].z, vt[k].cpi, vt[k].seq, vt[k].name);
        // Zero flips while sitting in BRANCH: PCWrite_1 must follow it combinationally.
        Opcode = BEQ;
        Zero = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("mealy state", 32'(State), 32'd8);
        chk("mealy zero0 pcw", 32'(PCWrite_1), 32'd0);
        Zero = 1'b1;
        #1;
        chk("mealy zero1 pcw", 32'(PCWrite_1), 32'd1);
        chk("mealy pcsrc", 32'(PCSource), 32'd1);
        @(negedge Clk);
        #1;
        chk("mealy return", 32'(State), 32'd0);
        // Asynchronous reset in MEMRD abandons the lw before the next edge.
        Opcode = LW;
        Zero = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("abort memrd", 32'(State), 32'd3);
        #2 Rst = 1'b0;
        #1;
        chk("abort async state", 32'(State), 32'd0);
        chk("abort async outs", 32'(outs), 32'd0);
        @(negedge Clk);
        #1;
        chk("abort held outs", 32'(outs), 32'd0);
        Rst = 1'b1;
        #1;
        chk("release fetch outs", 32'(outs), 32'(exp_out(4'd0, 6'd0, 1'b0)));
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 7)];
            fn = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
            seq_of(op, fn, cpi, seq);
            run(op, fn, 1'($urandom_range(0, 1)), cpi, seq, $sformatf("rand%0d", k));
        end
`ifdef ILLEGAL_TRAP_EN
        Opcode = BAD;
        #1;
        chk("halt fetch", 32'(State), 32'd0);
        @(negedge Clk);
        #1;
        chk("halt decode", 32'(State), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            #1;
            chk($sformatf("halt state%0d", k), 32'(State), 32'd14);
            chk($sformatf("halt outs%0d", k), 32'(outs), 32'd0);
        end
`else
        seq_of(BAD, 6'd0, cpi, seq);
        run(BAD, 6'd0, 1'b0, cpi, seq, "illegal_nop");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
